// File: rtl/omi_pkg.sv
// omi_pkg: shared state encoding and burst-length width for the OMI memory arbiter.
package omi_pkg;
    localparam int OMI_LEN_W = 8;
    typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_RRESP, ARB_WACK} omi_arb_state_t;
endpackage

// File: rtl/omi_rr_picker.sv
// omi_rr_picker: one-hot winner from a request vector; round-robin after last_grant, or lowest index when OMI_ARB_FIXED_PRIO_EN is defined.
module omi_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  win
);
`ifdef OMI_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
    // scan from the top so the lowest requesting index is written last and wins
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) begin
                win = '0;
                win[i] = 1'b1;
            end
    end
`else
    logic [IW-1:0] idx;
    // scan from farthest to nearest after last_grant so the nearest requester wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(last_grant) + i) % N);
            if (req[idx]) begin
                win = '0;
                win[idx] = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/omi_mem_arbiter.sv
// omi_mem_arbiter: shares one OMI memory port among N_MASTERS masters, grant locked per transaction; OMI_ARB_FIXED_PRIO_EN selects fixed priority.
module omi_mem_arbiter
    import omi_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [N_MASTERS-1:0]              i_m_req,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   i_m_addr,
    input  logic [N_MASTERS-1:0]              i_m_wen,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0] i_m_ben,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   i_m_data,
    input  logic [N_MASTERS*OMI_LEN_W-1:0]    i_m_len,
    output logic [N_MASTERS-1:0]              o_m_rdy,
    output logic [N_MASTERS-1:0]              o_m_valid,
    output logic [DATA_WIDTH-1:0]             o_m_data,
    output logic                              o_mem_req,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic                              o_mem_wen,
    output logic [DATA_WIDTH/8-1:0]           o_mem_ben,
    output logic [DATA_WIDTH-1:0]             o_mem_data,
    output logic [OMI_LEN_W-1:0]              o_mem_len,
    input  logic                              i_mem_rdy,
    input  logic                              i_mem_valid,
    input  logic [DATA_WIDTH-1:0]             i_mem_data
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;

    omi_arb_state_t       state, state_d;
    logic [IW-1:0]        g, g_d, last_grant, last_grant_d, win_idx;
    logic [OMI_LEN_W-1:0] cnt, cnt_d, win_len;
    logic [N_MASTERS-1:0] win;

    omi_rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
        .req        (i_m_req),
        .last_grant (last_grant),
        .win        (win)
    );

    // encode the one-hot winner as a master index
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (win[i]) win_idx = IW'(i);
    end

    assign win_len    = i_m_len[int'(win_idx)*OMI_LEN_W +: OMI_LEN_W];
    assign o_mem_addr = i_m_addr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_mem_wen  = i_m_wen[g];
    assign o_mem_ben  = i_m_ben[int'(g)*BW +: BW];
    assign o_mem_data = i_m_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    assign o_mem_len  = i_m_len[int'(g)*OMI_LEN_W +: OMI_LEN_W];
    assign o_m_data   = i_mem_data;

    // next state, beat counter and handshake routing for the locked master
    always_comb begin
        state_d      = state;
        g_d          = g;
        last_grant_d = last_grant;
        cnt_d        = cnt;
        o_mem_req    = 1'b0;
        o_m_rdy      = '0;
        o_m_valid    = '0;
        case (state)
            ARB_IDLE: if (|i_m_req) begin
                state_d      = ARB_XFER;
                g_d          = win_idx;
                last_grant_d = win_idx;
                cnt_d        = win_len;
            end
            ARB_XFER: begin
                o_mem_req  = i_m_req[g];
                o_m_rdy[g] = i_mem_rdy;
                if (i_m_req[g] && i_mem_rdy) begin
                    if (!o_mem_wen) begin
                        cnt_d   = o_mem_len;
                        state_d = ARB_RRESP;
                    end else if (cnt == '0) state_d = ARB_WACK;
                    else cnt_d = cnt - 1'b1;
                end
            end
            ARB_RRESP: begin
                o_m_valid[g] = i_mem_valid;
                if (i_mem_valid) begin
                    if (cnt == '0) state_d = ARB_IDLE;
                    else cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                o_m_valid[g] = i_mem_valid;
                if (i_mem_valid) state_d = ARB_IDLE;
            end
        endcase
    end

    // state, grant, round-robin pointer and beat counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            g          <= '0;
            last_grant <= IW'(N_MASTERS - 1);
            cnt        <= '0;
        end else begin
            state      <= state_d;
            g          <= g_d;
            last_grant <= last_grant_d;
            cnt        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_omi_mem_arbiter.sv
// tb_omi_mem_arbiter: random and directed stimulus checked cycle by cycle against a transaction-level arbiter model.
module tb_omi_mem_arbiter;
    localparam int N = 2, AW = 10, DW = 32, BW = DW / 8;
    localparam int FREE = 0, REQ = 1, RESP = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0]    i_m_req, i_m_wen, o_m_rdy, o_m_valid;
    logic [N*AW-1:0] i_m_addr;
    logic [N*BW-1:0] i_m_ben;
    logic [N*DW-1:0] i_m_data;
    logic [N*8-1:0]  i_m_len;
    logic [DW-1:0]   o_m_data, o_mem_data, i_mem_data;
    logic            o_mem_req, o_mem_wen, i_mem_rdy, i_mem_valid;
    logic [AW-1:0]   o_mem_addr;
    logic [BW-1:0]   o_mem_ben;
    logic [7:0]      o_mem_len;

    omi_mem_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_m_req(i_m_req), .i_m_addr(i_m_addr), .i_m_wen(i_m_wen), .i_m_ben(i_m_ben),
        .i_m_data(i_m_data), .i_m_len(i_m_len), .o_m_rdy(o_m_rdy), .o_m_valid(o_m_valid),
        .o_m_data(o_m_data), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_ben(o_mem_ben), .o_mem_data(o_mem_data), .o_mem_len(o_mem_len),
        .i_mem_rdy(i_mem_rdy), .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data)
    );

    always #5 clk = ~clk;

    bit            act[N], mw[N];
    int            ml[N], sent[N], vcnt[N];
    logic [AW-1:0] ma[N];
    logic [BW-1:0] mb[N];
    logic [DW-1:0] md[N];
    int            phase, owner, last, remain, wbeats;
    int            grants[$];
    int            p_start, p_wen, p_rdy, p_val, max_len;
    bit            rdy_toggle;
    int            n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rq(input int m);
        return act[m] && (mw[m] ? sent[m] <= ml[m] : sent[m] == 0);
    endfunction

    function automatic bit busy();
        bit b = phase != FREE;
        for (int m = 0; m < N; m++) b |= act[m];
        return b;
    endfunction

    function automatic int pick(input logic [N-1:0] r);
`ifdef OMI_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
`endif
        return 0;
    endfunction

    task automatic start(input int m, input bit w, input int len);
        act[m]  = 1'b1;
        mw[m]   = w;
        ml[m]   = len;
        sent[m] = 0;
        ma[m]   = AW'($urandom) & ~AW'(3);
        mb[m]   = BW'($urandom);
        md[m]   = $urandom;
    endtask

    task automatic pack();
        for (int m = 0; m < N; m++) begin
            i_m_req[m]           = rq(m);
            i_m_wen[m]           = mw[m];
            i_m_addr[m*AW +: AW] = ma[m];
            i_m_ben[m*BW +: BW]  = mb[m];
            i_m_data[m*DW +: DW] = md[m];
            i_m_len[m*8 +: 8]    = 8'(ml[m]);
        end
    endtask

    task automatic clear_stats();
        for (int m = 0; m < N; m++) vcnt[m] = 0;
        wbeats = 0;
        grants.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int m = 0; m < N; m++) begin
            act[m]  = 1'b0;
            sent[m] = 0;
        end
        phase = FREE;
        owner = 0;
        last  = N - 1;
        pack();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic cycle();
        logic [N-1:0] r, er, ev;
        bit ereq;
        for (int m = 0; m < N; m++)
            if (!act[m] && $urandom_range(99) < p_start)
                start(m, $urandom_range(99) < p_wen, int'($urandom_range(max_len)));
        i_mem_rdy   = rdy_toggle ? ~i_mem_rdy : ($urandom_range(99) < p_rdy);
        i_mem_valid = $urandom_range(99) < p_val;
        i_mem_data  = $urandom;
        pack();
        @(negedge clk);
        er = '0;
        ev = '0;
        ereq = 1'b0;
        for (int m = 0; m < N; m++) r[m] = rq(m);
        if (phase == REQ) begin
            ereq = 1'b1;
            er[owner] = i_mem_rdy;
            chk("mem_addr", 64'(o_mem_addr), 64'(ma[owner]));
            chk("mem_wen", 64'(o_mem_wen), 64'(mw[owner]));
            chk("mem_ben", 64'(o_mem_ben), 64'(mb[owner]));
            chk("mem_data", 64'(o_mem_data), 64'(md[owner]));
            chk("mem_len", 64'(o_mem_len), 64'(ml[owner]));
        end
        if (phase == RESP) ev[owner] = i_mem_valid;
        chk("mem_req", 64'(o_mem_req), 64'(ereq));
        chk("m_rdy", 64'(o_m_rdy), 64'(er));
        chk("m_valid", 64'(o_m_valid), 64'(ev));
        chk("m_data", 64'(o_m_data), 64'(i_mem_data));
        if (phase == FREE && |r) begin
            owner = pick(r);
            last  = owner;
            grants.push_back(owner);
            phase = REQ;
        end else if (phase == REQ && i_mem_rdy) begin
            sent[owner]++;
            if (mw[owner]) begin
                wbeats++;
                md[owner] = $urandom;
            end
            if (!rq(owner)) begin
                phase  = RESP;
                remain = mw[owner] ? 1 : ml[owner] + 1;
            end
        end else if (phase == RESP && i_mem_valid) begin
            vcnt[owner]++;
            remain--;
            if (remain == 0) begin
                act[owner] = 1'b0;
                phase = FREE;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_busy", 64'(busy()), 64'(0));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        p_start = 0; p_wen = 0; p_rdy = 100; p_val = 100; max_len = 7; rdy_toggle = 1'b0;
        i_mem_rdy = 1'b0; i_mem_data = '0;
        phase = FREE; owner = 0; last = N - 1;
        clear_stats();
        start(0, 1'b0, 2);
        start(1, 1'b1, 1);
        i_mem_valid = 1'b1;
        pack();
        @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(o_mem_req), 64'(0));
        chk("rst_m_rdy", 64'(o_m_rdy), 64'(0));
        chk("rst_m_valid", 64'(o_m_valid), 64'(0));
        chk("rst_mux_addr", 64'(o_mem_addr), 64'(ma[0]));
        chk("rst_mux_len", 64'(o_mem_len), 64'(2));
        do_reset();

        clear_stats();
        start(0, 1'b0, 0);
        run_idle(20);
        chk("single_v0", 64'(vcnt[0]), 64'(1));
        chk("single_v1", 64'(vcnt[1]), 64'(0));

        clear_stats();
        p_val = 100;
        repeat (8) cycle();
        start(1, 1'b0, 1);
        run_idle(30);
        chk("stray_v0", 64'(vcnt[0]), 64'(0));
        chk("stray_v1", 64'(vcnt[1]), 64'(2));

        clear_stats();
        rdy_toggle = 1'b1;
        start(1, 1'b1, 3);
        run_idle(40);
        rdy_toggle = 1'b0;
        chk("wr_beats", 64'(wbeats), 64'(4));
        chk("wr_ack_v1", 64'(vcnt[1]), 64'(1));
        chk("wr_ack_v0", 64'(vcnt[0]), 64'(0));

        clear_stats();
        p_val = 70;
        start(0, 1'b0, 255);
        run_idle(2000);
        chk("len255_v0", 64'(vcnt[0]), 64'(256));
        chk("len255_v1", 64'(vcnt[1]), 64'(0));

        do_reset();
        clear_stats();
        p_start = 100; p_wen = 0; max_len = 3; p_rdy = 70; p_val = 60;
        repeat (120) cycle();
        p_start = 0;
        run_idle(200);
        chk("alt_count", 64'(grants.size() >= 6), 64'(1));
        for (int i = 0; i < 6 && i < grants.size(); i++)
`ifdef OMI_ARB_FIXED_PRIO_EN
            chk("alt_grant", 64'(grants[i]), 64'(0));
`else
            chk("alt_grant", 64'(grants[i]), 64'(i % 2));
`endif

        clear_stats();
        p_val = 100; p_rdy = 100;
        start(0, 1'b0, 20);
        for (int k = 0; k < 100 && !(phase == RESP && vcnt[0] >= 3); k++) cycle();
        i_mem_valid = 1'b1;
        #2;
        chk("pre_rst_valid", 64'(o_m_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_m_valid), 64'(0));
        chk("async_rst_req", 64'(o_mem_req), 64'(0));
        chk("async_rst_rdy", 64'(o_m_rdy), 64'(0));
        do_reset();
        clear_stats();
        start(0, 1'b0, 0);
        start(1, 1'b0, 0);
        run_idle(30);
        chk("post_rst_grants", 64'(grants.size()), 64'(2));
        if (grants.size() > 0) chk("post_rst_first", 64'(grants[0]), 64'(0));

        clear_stats();
        p_start = 30; p_wen = 50; max_len = 7; p_rdy = 60; p_val = 50;
        repeat (1500) cycle();
        p_start = 0;
        run_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
